// File: rtl/cu_store_responder_pkg.sv
// Shared constants and FSM encoding for the DFU store-path responder.
// Register addresses, bus widths and the row-transfer state type live here.
package cu_store_responder_pkg;

    localparam int FIFO_WIDTH_DEF = 32;
    localparam int SRAM_AW_DEF    = 12;
    localparam int MAX_LEN_DEF    = 64;

    localparam logic [31:0] CU_LENGTH_DEF    = 32'h10;
    localparam logic [31:0] CU_SRAM_ADDR_DEF = 32'h14;
    localparam logic [31:0] CU_DRAM_ADDR_DEF = 32'h18;

    // Slot order of the three configuration registers inside the decoder
    localparam int NUM_REGS = 3;
    localparam int REG_LEN  = 0;
    localparam int REG_ROW  = 1;
    localparam int REG_DRAM = 2;

    typedef enum logic [2:0] {
        ST_CFG,
        ST_ACK,
        ST_WAIT_INT,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/cu_store_regdec.sv
// Configuration register decoder: latches length, SRAM row and DRAM address writes,
// tracks which of them have been loaded, and flags writes to unknown addresses.
module cu_store_regdec
    import cu_store_responder_pkg::*;
#(
    parameter int                    FIFO_WIDTH   = FIFO_WIDTH_DEF,
    parameter logic [FIFO_WIDTH-1:0] CU_LENGTH    = FIFO_WIDTH'(CU_LENGTH_DEF),
    parameter logic [FIFO_WIDTH-1:0] CU_SRAM_ADDR = FIFO_WIDTH'(CU_SRAM_ADDR_DEF),
    parameter logic [FIFO_WIDTH-1:0] CU_DRAM_ADDR = FIFO_WIDTH'(CU_DRAM_ADDR_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  req,
    input  logic                  addr_vld,
    input  logic                  data_vld,
    input  logic [FIFO_WIDTH-1:0] addr,
    input  logic [FIFO_WIDTH-1:0] data,
    output logic [FIFO_WIDTH-1:0] len,
    output logic [FIFO_WIDTH-1:0] row,
    output logic [FIFO_WIDTH-1:0] dram,
    output logic                  all_loaded,
    output logic                  any_loaded,
    output logic                  err
);

    logic                  wr_stb;
    logic [NUM_REGS-1:0]   hit;
    logic [NUM_REGS-1:0]   loaded_vec;
    logic [FIFO_WIDTH-1:0] val_vec [NUM_REGS];
    logic                  err_reg;

    assign wr_stb = en && req && addr_vld && data_vld;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [FIFO_WIDTH-1:0] ADDR =
                (gi == REG_LEN) ? CU_LENGTH :
                (gi == REG_ROW) ? CU_SRAM_ADDR : CU_DRAM_ADDR;

            logic [FIFO_WIDTH-1:0] val_reg;
            logic                  loaded_reg;

            assign hit[gi] = wr_stb && (addr == ADDR);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    val_reg    <= '0;
                    loaded_reg <= 1'b0;
                end else begin
                    if (hit[gi])
                        val_reg <= data;
                    if (clr)
                        loaded_reg <= 1'b0;
                    else if (hit[gi])
                        loaded_reg <= 1'b1;
                end
            end

            assign val_vec[gi]    = val_reg;
            assign loaded_vec[gi] = loaded_reg;
        end
    endgenerate

    // A write that matches none of the three registers is dropped but reported
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_reg <= 1'b0;
        else
            err_reg <= wr_stb && (hit == '0);
    end

    assign len        = val_vec[REG_LEN];
    assign row        = val_vec[REG_ROW];
    assign dram       = val_vec[REG_DRAM];
    assign all_loaded = &loaded_vec;
    assign any_loaded = |loaded_vec;
    assign err        = err_reg;

endmodule

// File: rtl/cu_store_responder.sv
// Arbiter-side responder for the DFU store path: acknowledges the configuration
// writes, then on read_interrupt copies one SRAM row to DRAM a word at a time.
module cu_store_responder
    import cu_store_responder_pkg::*;
#(
    parameter int                    FIFO_WIDTH   = FIFO_WIDTH_DEF,
    parameter int                    SRAM_AW      = SRAM_AW_DEF,
    parameter int                    MAX_LEN      = MAX_LEN_DEF,
    parameter logic [FIFO_WIDTH-1:0] CU_LENGTH    = FIFO_WIDTH'(CU_LENGTH_DEF),
    parameter logic [FIFO_WIDTH-1:0] CU_SRAM_ADDR = FIFO_WIDTH'(CU_SRAM_ADDR_DEF),
    parameter logic [FIFO_WIDTH-1:0] CU_DRAM_ADDR = FIFO_WIDTH'(CU_DRAM_ADDR_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ar_rd_req,
    input  logic [FIFO_WIDTH-1:0] ar_rd_addr,
    input  logic                  ar_rd_addr_vld,
    input  logic [FIFO_WIDTH-1:0] ar_rd_data,
    input  logic                  ar_rd_data_vld,
    output logic                  ar2dfu_ack,
    input  logic                  read_interrupt,
    output logic                  sram_rd_en,
    output logic [SRAM_AW-1:0]    sram_rd_addr,
    input  logic [FIFO_WIDTH-1:0] sram_rd_data,
    output logic                  dram_wr_req,
    output logic [FIFO_WIDTH-1:0] dram_wr_addr,
    output logic [FIFO_WIDTH-1:0] dram_wr_data,
    input  logic                  dram_wr_ready,
    output logic                  ack_sram_c_rd,
    output logic                  busy,
    output logic                  err
);

    localparam int IDX_W = $clog2(MAX_LEN + 1);

    state_t                state_reg, state_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic                  len_err_reg, len_err_next;
    logic                  wr_first_reg;
    logic [FIFO_WIDTH-1:0] wr_data_reg;

    logic [FIFO_WIDTH-1:0] len_val, row_val, dram_val;
    logic                  all_loaded, any_loaded, cfg_err;
    logic                  len_legal, last_beat;

    cu_store_regdec #(
        .FIFO_WIDTH   (FIFO_WIDTH),
        .CU_LENGTH    (CU_LENGTH),
        .CU_SRAM_ADDR (CU_SRAM_ADDR),
        .CU_DRAM_ADDR (CU_DRAM_ADDR)
    ) u_regdec (
        .clk        (clk),
        .rst        (rst),
        .en         (state_reg == ST_CFG),
        .clr        (state_reg == ST_DONE),
        .req        (ar_rd_req),
        .addr_vld   (ar_rd_addr_vld),
        .data_vld   (ar_rd_data_vld),
        .addr       (ar_rd_addr),
        .data       (ar_rd_data),
        .len        (len_val),
        .row        (row_val),
        .dram       (dram_val),
        .all_loaded (all_loaded),
        .any_loaded (any_loaded),
        .err        (cfg_err)
    );

    assign len_legal = (len_val != '0) && (len_val <= FIFO_WIDTH'(MAX_LEN));
    assign last_beat = (FIFO_WIDTH'(idx_reg) == (len_val - FIFO_WIDTH'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_CFG;
            idx_reg      <= '0;
            len_err_reg  <= 1'b0;
            wr_first_reg <= 1'b0;
            wr_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            len_err_reg  <= len_err_next;
            wr_first_reg <= (state_reg == ST_RD);
            if (wr_first_reg)
                wr_data_reg <= sram_rd_data;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        len_err_next = 1'b0;
        case (state_reg)
            ST_CFG:      if (all_loaded) state_next = ST_ACK;
            ST_ACK:      state_next = ST_WAIT_INT;
            ST_WAIT_INT: begin
                if (read_interrupt) begin
                    if (len_legal) begin
                        state_next = ST_RD;
                    end else begin
                        state_next   = ST_DONE;
                        len_err_next = 1'b1;
                    end
                end
            end
            ST_RD:       state_next = ST_WR;
            ST_WR: begin
                if (dram_wr_ready) begin
                    if (last_beat) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = ST_RD;
                    end
                end
            end
            ST_DONE: begin
                idx_next   = '0;
                state_next = ST_CFG;
            end
            default:     state_next = ST_CFG;
        endcase
    end

    // SRAM data is live only in the first WR cycle; later stall cycles replay the captured copy
    assign dram_wr_data  = wr_first_reg ? sram_rd_data : wr_data_reg;
    assign dram_wr_addr  = dram_val + FIFO_WIDTH'(idx_reg);
    assign dram_wr_req   = (state_reg == ST_WR);
    assign sram_rd_en    = (state_reg == ST_RD);
    assign sram_rd_addr  = sram_rd_en ?
                           SRAM_AW'(row_val * len_val + FIFO_WIDTH'(idx_reg)) : '0;
    assign ar2dfu_ack    = (state_reg == ST_ACK);
    assign ack_sram_c_rd = (state_reg == ST_DONE);
    assign busy          = (state_reg == ST_CFG) ? any_loaded : (state_reg != ST_DONE);
    assign err           = cfg_err | len_err_reg;

endmodule

// File: tb/tb_cu_store_responder.sv
// Scoreboard bench for cu_store_responder: expected SRAM reads and DRAM beats are
// queued from a row-level model, a negedge monitor pops and compares them.
module tb_cu_store_responder;

    localparam int FW = 32;
    localparam int AW = 12;
    localparam logic [31:0] A_LEN  = 32'h10;
    localparam logic [31:0] A_ROW  = 32'h14;
    localparam logic [31:0] A_DRAM = 32'h18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ar_rd_req = 1'b0, ar_rd_addr_vld = 1'b0, ar_rd_data_vld = 1'b0;
    logic [FW-1:0] ar_rd_addr = '0, ar_rd_data = '0;
    logic          ar2dfu_ack;
    logic          read_interrupt = 1'b0;
    logic          sram_rd_en;
    logic [AW-1:0] sram_rd_addr;
    logic [FW-1:0] sram_rd_data = '0;
    logic          dram_wr_req;
    logic [FW-1:0] dram_wr_addr, dram_wr_data;
    logic          dram_wr_ready = 1'b1;
    logic          ack_sram_c_rd, busy, err;

    always #5 clk = ~clk;

    cu_store_responder dut (
        .clk            (clk),
        .rst            (rst),
        .ar_rd_req      (ar_rd_req),
        .ar_rd_addr     (ar_rd_addr),
        .ar_rd_addr_vld (ar_rd_addr_vld),
        .ar_rd_data     (ar_rd_data),
        .ar_rd_data_vld (ar_rd_data_vld),
        .ar2dfu_ack     (ar2dfu_ack),
        .read_interrupt (read_interrupt),
        .sram_rd_en     (sram_rd_en),
        .sram_rd_addr   (sram_rd_addr),
        .sram_rd_data   (sram_rd_data),
        .dram_wr_req    (dram_wr_req),
        .dram_wr_addr   (dram_wr_addr),
        .dram_wr_data   (dram_wr_data),
        .dram_wr_ready  (dram_wr_ready),
        .ack_sram_c_rd  (ack_sram_c_rd),
        .busy           (busy),
        .err            (err)
    );

    // SRAM model: one-cycle registered read
    logic [FW-1:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clk) if (sram_rd_en) sram_rd_data <= sram_mem[sram_rd_addr];

    typedef struct { logic [31:0] a; logic [31:0] d; } beat_t;
    logic [31:0] exp_sram_q[$];
    beat_t       exp_beat_q[$];

    int n_cmp = 0, n_bad = 0;
    int ack_cnt = 0, done_cnt = 0, err_cnt = 0, rd_cnt = 0, beat_cnt = 0;
    int stall_beat = -1, stall_left = 0;
    bit rand_ready = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts pulses, pops the scoreboard, checks stall stability
    initial begin
        logic        pend;
        logic [31:0] pend_a, pend_d, e;
        beat_t       b;
        pend = 0; pend_a = 0; pend_d = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 0;
            end else begin
                if (ar2dfu_ack)    ack_cnt++;
                if (ack_sram_c_rd) done_cnt++;
                if (err)           err_cnt++;
                if (sram_rd_en) begin
                    rd_cnt++;
                    check("sram_rd_expected", exp_sram_q.size() != 0, 1);
                    if (exp_sram_q.size() != 0) begin
                        e = exp_sram_q.pop_front();
                        check("sram_rd_addr", sram_rd_addr, e);
                    end
                end
                if (pend) begin
                    check("wr_req_held", dram_wr_req, 1);
                    check("wr_addr_held", dram_wr_addr, pend_a);
                    check("wr_data_held", dram_wr_data, pend_d);
                end
                if (dram_wr_req && dram_wr_ready) begin
                    beat_cnt++;
                    pend = 0;
                    check("beat_expected", exp_beat_q.size() != 0, 1);
                    if (exp_beat_q.size() != 0) begin
                        b = exp_beat_q.pop_front();
                        $display("beat addr=0x%08h data=0x%08h exp_addr=0x%08h exp_data=0x%08h",
                                 dram_wr_addr, dram_wr_data, b.a, b.d);
                        check("beat_addr", dram_wr_addr, b.a);
                        check("beat_data", dram_wr_data, b.d);
                    end
                end else if (dram_wr_req) begin
                    pend = 1; pend_a = dram_wr_addr; pend_d = dram_wr_data;
                end else begin
                    pend = 0;
                end
            end
        end
    end

    // DRAM ready driver: always ready, random, or a targeted stall on one beat
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0 && beat_cnt == stall_beat && dram_wr_req) begin
                dram_wr_ready = 1'b0;
                stall_left--;
            end else if (rand_ready)
                dram_wr_ready = ($urandom_range(0, 3) != 0);
            else
                dram_wr_ready = 1'b1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ar_rd_req = 1; ar_rd_addr_vld = 1; ar_rd_data_vld = 1;
        ar_rd_addr = a; ar_rd_data = d;
        tick();
        ar_rd_req = 0; ar_rd_addr_vld = 0; ar_rd_data_vld = 0;
        $display("write addr=0x%0h data=0x%0h", a, d);
    endtask

    task automatic wait_ack();
        int n = 0;
        int a0 = ack_cnt;
        while (!ar2dfu_ack && n < 4) begin tick(); n++; end
        check("ack_seen", ar2dfu_ack, 1);
        tick();
        check("ack_count", ack_cnt - a0, 1);
    endtask

    task automatic config_row(input logic [31:0] len, input logic [31:0] row, input logic [31:0] dram);
        int order = $urandom_range(0, 2);
        if (order == 0) begin wr(A_LEN, len); wr(A_ROW, row); wr(A_DRAM, dram); end
        else if (order == 1) begin wr(A_DRAM, dram); wr(A_LEN, len); wr(A_ROW, row); end
        else begin wr(A_ROW, row); wr(A_DRAM, dram); wr(A_LEN, len); end
        wait_ack();
    endtask

    task automatic push_row(input logic [31:0] len, input logic [31:0] row, input logic [31:0] dram);
        logic [31:0] sa;
        beat_t b;
        for (int i = 0; i < int'(len); i++) begin
            sa = (row * len + i) & 32'hFFF;
            exp_sram_q.push_back(sa);
            b.a = dram + i;
            b.d = sram_mem[sa[AW-1:0]];
            exp_beat_q.push_back(b);
        end
    endtask

    task automatic run_row(input logic [31:0] len, input logic [31:0] row,
                           input logic [31:0] dram, input bit check_lat);
        int n = 0;
        int r0 = rd_cnt, b0 = beat_cnt, d0 = done_cnt, e0 = err_cnt;
        bit legal = (len != 0) && (len <= 64);
        if (legal) push_row(len, row, dram);
        read_interrupt = 1;
        do begin
            tick(); read_interrupt = 0; n++;
        end while (!ack_sram_c_rd && n < 2000);
        check("row_done_seen", ack_sram_c_rd, 1);
        if (check_lat) check("row_latency", n, legal ? 2 * len + 1 : 1);
        tick();
        $display("row len=%0d row=%0d dram=0x%08h cycles=%0d", len, row, dram, n);
        check("row_sram_reads", rd_cnt - r0, legal ? len : 0);
        check("row_beats", beat_cnt - b0, legal ? len : 0);
        check("row_done_count", done_cnt - d0, 1);
        check("row_err_count", err_cnt - e0, legal ? 0 : 1);
        check("row_queues_empty", exp_sram_q.size() + exp_beat_q.size(), 0);
        check("busy_after_row", busy, 0);
    endtask

    initial begin
        int a0, e0, r0, b0, d0, n;
        logic [31:0] len, row, dram;
        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = $urandom;

        // Reset state
        #2;
        check("rst_ack", ar2dfu_ack, 0);
        check("rst_sram_rd_en", sram_rd_en, 0);
        check("rst_sram_rd_addr", sram_rd_addr, 0);
        check("rst_dram_wr_req", dram_wr_req, 0);
        check("rst_dram_wr_addr", dram_wr_addr, 0);
        check("rst_dram_wr_data", dram_wr_data, 0);
        check("rst_done", ack_sram_c_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        tick(); tick(); rst = 1; tick();

        // 1: basic row
        wr(A_LEN, 4);
        check("busy_after_write", busy, 1);
        wr(A_ROW, 2); wr(A_DRAM, 32'h100);
        wait_ack();
        run_row(4, 2, 32'h100, 1);

        // 2: repeated DRAM address writes, last wins
        a0 = ack_cnt;
        wr(A_DRAM, 32'h100); wr(A_DRAM, 32'h140); wr(A_LEN, 4); wr(A_ROW, 2);
        wait_ack();
        check("repeat_ack_total", ack_cnt - a0, 1);
        run_row(4, 2, 32'h140, 1);

        // 3: ready stalled five cycles on beat 2
        config_row(4, 7, 32'h500);
        stall_beat = beat_cnt + 1; stall_left = 5;
        run_row(4, 7, 32'h500, 0);
        check("stall_consumed", stall_left, 0);

        // 4: zero length
        config_row(0, 3, 32'h600);
        run_row(0, 3, 32'h600, 1);

        // 5: unknown address, early interrupt
        e0 = err_cnt; a0 = ack_cnt; r0 = rd_cnt; d0 = done_cnt;
        wr(32'h1C, 32'hDEAD); tick();
        check("unknown_addr_err", err_cnt - e0, 1);
        wr(A_LEN, 4); wr(A_ROW, 3);
        read_interrupt = 1; tick(); read_interrupt = 0;
        tick(); tick(); tick();
        check("early_int_no_ack", ack_cnt - a0, 0);
        check("early_int_no_rd", rd_cnt - r0, 0);
        check("early_int_no_done", done_cnt - d0, 0);
        check("early_int_no_err", err_cnt - e0, 1);
        wr(A_DRAM, 32'h200);
        wait_ack();
        run_row(4, 3, 32'h200, 1);

        // 6: reset during beat 3 of len=8, then clean re-run
        config_row(8, 5, 32'h3000);
        b0 = beat_cnt;
        push_row(8, 5, 32'h3000);
        read_interrupt = 1; tick(); read_interrupt = 0;
        n = 0;
        while (!(dram_wr_req && beat_cnt == b0 + 2) && n < 100) begin tick(); n++; end
        check("beat3_reached", dram_wr_req && beat_cnt == b0 + 2, 1);
        #2 rst = 0;
        #1;
        check("midrst_req", dram_wr_req, 0);
        check("midrst_rd_en", sram_rd_en, 0);
        check("midrst_ack", ar2dfu_ack, 0);
        check("midrst_done", ack_sram_c_rd, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wr_addr", dram_wr_addr, 0);
        exp_sram_q.delete(); exp_beat_q.delete();
        tick(); tick(); rst = 1; tick();
        config_row(8, 5, 32'h3000);
        run_row(8, 5, 32'h3000, 1);

        // Randomized rows with random DRAM backpressure
        rand_ready = 1;
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = 65 + $urandom_range(0, 40);
                2:       len = 64;
                default: len = $urandom_range(1, 12);
            endcase
            row  = $urandom_range(0, 300);
            dram = (k == 3) ? 32'hFFFF_FFFE : $urandom;
            config_row(len, row, dram);
            run_row(len, row, dram, 0);
        end
        rand_ready = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
